load_writeback: RTL

Load writeback stage directly downstream of the load/store unit. Captures each issued load's opcode, destination register and low address bits, then formats the 32-bit data memory read word one cycle later: byte/halfword extraction plus sign or zero extension. Delivers the result to the register-file write port, which it shares with the ALU. ALU writes have priority; displaced load results wait in a 2-entry queue. Also exports a pending-destination mask for hazard detection, and a stall to the issue logic.

---
 rtl/load_writeback_pkg.sv | 24 ++
 rtl/load_align.sv | 29 ++
 rtl/load_writeback.sv | 139 +++++++++++++
 3 files changed

// File: rtl/load_writeback_pkg.sv
// Shared load/store types and the load writeback queue entry layout.
package load_writeback_pkg;

    typedef enum logic [2:0] {
        i_LB  = 3'b000,
        i_LH  = 3'b001,
        i_LW  = 3'b010,
        i_LBU = 3'b100,
        i_LHU = 3'b101
    } ls_op_t;

    localparam int LDQ_DEPTH = 2;

    typedef struct packed {
        logic        valid;
        logic [4:0]  rd;
        logic [31:0] data;
    } ld_entry_t;

    function automatic logic [31:0] rd_onehot(input logic [4:0] rd);
        return 32'd1 << rd;
    endfunction

endpackage

// File: rtl/load_align.sv
// Formats a 32-bit memory word per load kind and byte offset (byte/half select, sign/zero extend).
// Purely combinational, no state and no flow control.
module load_align
    import load_writeback_pkg::*;
(
    input  ls_op_t      i_op,
    input  logic [1:0]  i_off,
    input  logic [31:0] i_word,
    output logic [31:0] o_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = i_word[{i_off, 3'b000} +: 8];
        w_half = i_off[1] ? i_word[31:16] : i_word[15:0];
        o_data = i_word;
        case (i_op)
            i_LB:    o_data = {{24{w_byte[7]}}, w_byte};
            i_LBU:   o_data = {24'd0, w_byte};
            i_LH:    o_data = {{16{w_half[15]}}, w_half};
            i_LHU:   o_data = {16'd0, w_half};
            i_LW:    o_data = i_word;
            default: o_data = i_word;
        endcase
    end

endmodule

// File: rtl/load_writeback.sv
// Load writeback: stages issued loads, formats read data, shares the RF write port with the ALU (ALU wins).
// One-cycle latency uncontended; displaced results queue (depth 2) and ld_stall holds off issue when S+queue reach 2.
module load_writeback
    import load_writeback_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        ld_issue,
    input  ls_op_t      ld_op,
    input  logic [4:0]  ld_rd_addr,
    input  logic [1:0]  ld_addr_lo,
    input  logic [31:0] d_rd_data,
    input  logic        alu_we,
    input  logic [4:0]  alu_rd_addr,
    input  logic [31:0] alu_wr_data,
    output logic        rf_we,
    output logic [4:0]  rf_wr_addr,
    output logic [31:0] rf_wr_data,
    output logic        ld_stall,
    output logic [31:0] busy_mask
);

    logic        r_s_vld;
    ls_op_t      r_s_op;
    logic [4:0]  r_s_rd;
    logic [1:0]  r_s_off;

    ld_entry_t   r_q [LDQ_DEPTH];
    logic        r_rd_ptr;
    logic        r_wr_ptr;

    logic [31:0] w_s_data;
    logic        w_s_live;
    logic [1:0]  w_q_cnt;
    logic        w_q_live [LDQ_DEPTH];
    logic        w_head_live;
    logic        w_tail_live;
    ld_entry_t   w_head;
    logic        w_pop;
    logic        w_push;
    ld_entry_t   w_q_n [LDQ_DEPTH];
    logic        w_rd_ptr_n;
    logic        w_wr_ptr_n;

    load_align u_align (
        .i_op   (r_s_op),
        .i_off  (r_s_off),
        .i_word (d_rd_data),
        .o_data (w_s_data)
    );

    // A younger ALU write to the same rd makes the pending load result dead.
    assign w_s_live = r_s_vld && !(alu_we && (alu_rd_addr == r_s_rd));
    assign w_q_cnt  = {1'b0, r_q[0].valid} + {1'b0, r_q[1].valid};
    assign ld_stall = (w_q_cnt + {1'b0, r_s_vld}) >= 2'd2;

    always_comb begin
        w_q_n      = r_q;
        w_rd_ptr_n = r_rd_ptr;
        for (int i = 0; i < LDQ_DEPTH; i++) begin
            w_q_live[i] = r_q[i].valid && !(alu_we && (r_q[i].rd == alu_rd_addr));
            w_q_n[i].valid = w_q_live[i];
        end
        // Killed entries are squeezed out so live entries stay contiguous from the read pointer.
        w_head_live = w_q_n[r_rd_ptr].valid;
        w_tail_live = w_q_n[~r_rd_ptr].valid;
        if (!w_head_live && w_tail_live) begin
            w_rd_ptr_n = ~r_rd_ptr;
        end
        w_wr_ptr_n = (w_head_live ^ w_tail_live) ? ~w_rd_ptr_n : w_rd_ptr_n;

        w_head = w_q_n[w_rd_ptr_n];
        w_pop  = !alu_we && w_head.valid;
        w_push = w_s_live && (alu_we || w_head.valid);
        if (w_pop) begin
            w_q_n[w_rd_ptr_n].valid = 1'b0;
            w_rd_ptr_n = ~w_rd_ptr_n;
        end
        if (w_push) begin
            w_q_n[w_wr_ptr_n] = '{valid: 1'b1, rd: r_s_rd, data: w_s_data};
            w_wr_ptr_n = ~w_wr_ptr_n;
        end
    end

    always_comb begin
        rf_we      = 1'b0;
        rf_wr_addr = 5'd0;
        rf_wr_data = 32'd0;
        if (alu_we) begin
            rf_we      = 1'b1;
            rf_wr_addr = alu_rd_addr;
            rf_wr_data = alu_wr_data;
        end else if (w_pop) begin
            rf_we      = 1'b1;
            rf_wr_addr = w_head.rd;
            rf_wr_data = w_head.data;
        end else if (w_s_live) begin
            rf_we      = 1'b1;
            rf_wr_addr = r_s_rd;
            rf_wr_data = w_s_data;
        end
    end

    always_comb begin
        busy_mask = 32'd0;
        if (w_s_live) begin
            busy_mask = busy_mask | rd_onehot(r_s_rd);
        end
        for (int i = 0; i < LDQ_DEPTH; i++) begin
            if (w_q_live[i]) begin
                busy_mask = busy_mask | rd_onehot(r_q[i].rd);
            end
        end
        busy_mask[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_s_vld  <= 1'b0;
            r_s_op   <= i_LB;
            r_s_rd   <= 5'd0;
            r_s_off  <= 2'd0;
            r_q      <= '{default: '0};
            r_rd_ptr <= 1'b0;
            r_wr_ptr <= 1'b0;
        end else begin
            r_s_vld  <= ld_issue && (ld_rd_addr != 5'd0);
            r_s_op   <= ld_op;
            r_s_rd   <= ld_rd_addr;
            r_s_off  <= ld_addr_lo;
            r_q      <= w_q_n;
            r_rd_ptr <= w_rd_ptr_n;
            r_wr_ptr <= w_wr_ptr_n;
        end
    end

    a_no_issue_when_stalled: assert property (@(posedge clk) disable iff (!rst) !(ld_issue && ld_stall));

endmodule
